n64adv2_hdmi_clksw_ctrl: RTL and testbench
==========================================

# n64adv2_hdmi_clksw_ctrl

Sequencer for the HDMI output clock mux select and the HDMI-domain hold reset. It debounces the requested clock selection (main/sub) coming from the resolution and low-latency logic. On a confirmed change it mutes the transmitter, holds the HDMI pipeline in reset, switches the clock select, waits for settle and PLL lock, then releases reset and handshakes a transmitter reconfiguration with the NIOS II. It runs in the system clock domain and drives the clock-control select and the async reset input of the HDMI reset generator.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive mismatched samples required before a switch starts (≥2).
- MUTE_CYCLES, 256: cycles mute is asserted before the clock select changes (≥1).
- SETTLE_CYCLES, 64: minimum cycles held in reset after the select changes (≥1).
- ACK_TIMEOUT, 65535: maximum wait for the reconfiguration acknowledge; used only with the timeout feature.

Ports:
- SYS_CLK_i  in  1  system clock; all logic is on its rising edge.
- nSRST_i  in  1  reset, **asynchronous assert, active-low**.
- HDMI_cfg_done_i  in  1  transmitter initial configuration done; already synchronised.
- HDMI_PLL_locked_i  in  1  HDMI PLL lock; already synchronised.
- clksel_req_i  in  1  requested select: 0 = main, 1 = sub.
- reconfig_ack_i  in  1  NIOS acknowledge, level.
- clksel_o  out  1  applied select fed to the clock-control block.
- HDMI_hold_nRST_o  out  1  active-low hold, ANDed into the HDMI async reset.
- HDMI_mute_o  out  1  transmitter AV mute request.
- reconfig_req_o  out  1  reconfiguration request, level.
- busy_o  out  1  high in any state except IDLE.
- timeout_o  out  1  sticky acknowledge-timeout flag.

## Operation
- States: BOOT, IDLE, MUTE, SWITCH, SETTLE, RELEASE.
- Reset values: state = BOOT, clksel_o = 0, HDMI_hold_nRST_o = 0, HDMI_mute_o = 1, reconfig_req_o = 0, busy_o = 1, timeout_o = 0, counters = 0.
- BOOT:
  - hold = 0, mute = 1.
  - When HDMI_cfg_done_i = 1: load clksel_o from clksel_req_i, go to SETTLE.
- IDLE:
  - hold = 1, mute = 0.
  - The debounce counter increments while clksel_req_i ≠ clksel_o and clears to 0 on any equal sample.
  - On a mismatched sample with counter = DEBOUNCE_CYCLES−1: latch target = clksel_req_i, clear the counter, go to MUTE.
- MUTE:
  - mute = 1, hold = 1.
  - The counter runs 0 to MUTE_CYCLES−1, then go to SWITCH.
- SWITCH (one cycle):
  - hold = 0, mute = 1.
  - clksel_o ← target at exit.
- SETTLE:
  - hold = 0, mute = 1.
  - Exit to RELEASE once the counter has reached SETTLE_CYCLES−1 and HDMI_PLL_locked_i = 1 on the same sample.
  - The counter saturates while waiting for lock.
- RELEASE:
  - hold = 1, mute = 1, reconfig_req_o = 1.
  - On reconfig_ack_i = 1: reconfig_req_o = 0, go to IDLE; mute drops on IDLE entry.
- Boundary conditions:
  - A request toggling back during debounce aborts without side effects.
  - Request changes after MUTE entry are ignored until IDLE; IDLE then re-compares and starts a new sequence if a mismatch remains.
  - HDMI_cfg_done_i falling in any state → BOOT next cycle. BOOT keeps clksel_o; it reloads it on exit.
  - A lock loss in IDLE is not acted on.
  - nSRST_i low mid-sequence forces all reset values immediately.
  - ack already high on RELEASE entry: exit after exactly one RELEASE cycle.

## Timing
- Request latency (first mismatched IDLE sample at edge k):
  - MUTE is entered at edge k+DEBOUNCE_CYCLES−1.
  - clksel_o changes at edge k+DEBOUNCE_CYCLES+MUTE_CYCLES.
- Reset hold: HDMI_hold_nRST_o is low for at least SETTLE_CYCLES+1 cycles around the select change.
- Glitch behaviour: clksel_o never changes while HDMI_hold_nRST_o = 1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- HDMI_CLKSW_ACK_TIMEOUT_EN defined:
  - RELEASE counts cycles; after ACK_TIMEOUT cycles without ack: set timeout_o (sticky until reset), drop reconfig_req_o, go to IDLE.
- HDMI_CLKSW_ACK_TIMEOUT_EN undefined:
  - RELEASE waits indefinitely.
  - timeout_o is tied to 0.
  - The ACK_TIMEOUT counter is not built.

## Structure
- Shared package/header:
  - state encoding constants.
  - the CLKSEL_MAIN = 0 / CLKSEL_SUB = 1 constants, shared with the resolution select logic.
- One sub-module, n64adv2_cycle_counter: loadable, saturating, 16-bit, terminal-count output. It is reused for the debounce, mute, settle and timeout counts.

## Test plan
- Reset release with HDMI_cfg_done_i = 1, req = 1, lock = 1 → clksel_o = 1 after BOOT. Hold rises 65 cycles later; reconfig_req_o waits for ack.
- In IDLE, req 0→1 held → clksel_o changes exactly 16+256 edges after the first mismatch. Hold is low at that edge; mute is high throughout.
- Req pulse of 10 cycles → no state change. The debounce counter returns to 0.
- Lock low during SETTLE for 500 cycles → hold stays low until lock rises, then releases on the next sample.
- With HDMI_CLKSW_ACK_TIMEOUT_EN and ACK_TIMEOUT = 100, no ack → timeout_o = 1 and IDLE after 100 RELEASE cycles. Without the macro the block stays in RELEASE.
- HDMI_cfg_done_i dropped during MUTE → BOOT next cycle with hold = 0 and mute = 1.

Source files
------------

// File: rtl/n64adv2_hdmi_clksw_ctrl_pkg.sv
// rtl/n64adv2_hdmi_clksw_ctrl_pkg.sv - shared constants and state encoding for the HDMI clock-switch sequencer
// Contents: CLKSEL_MAIN/CLKSEL_SUB select values, clksw_state_e state encoding,
//           cycles_to_tc() helper turning a cycle count into a terminal count.
package n64adv2_hdmi_clksw_ctrl_pkg;

  // Clock-control select values, shared with the resolution select logic.
  localparam logic CLKSEL_MAIN = 1'b0;
  localparam logic CLKSEL_SUB  = 1'b1;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_MUTE    = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_RELEASE = 3'd5
  } clksw_state_e;

  // A count of N cycles ends when a counter starting at 0 reads N-1.
  function automatic logic [15:0] cycles_to_tc(input int cycles);
    return 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/n64adv2_cycle_counter.sv
// rtl/n64adv2_cycle_counter.sv - loadable 16-bit saturating up-counter with terminal-count flag
// Ports:
//   clk_i       in   clock (rising edge)
//   rst_n_i     in   asynchronous active-low reset, clears the count
//   load_i      in   load load_val_i (has priority over en_i)
//   en_i        in   count up; holds once the count equals term_i
//   load_val_i  in   [15:0] value loaded by load_i
//   term_i      in   [15:0] terminal count
//   tc_o        out  count equals term_i
module n64adv2_cycle_counter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] load_val_i,
  input  logic [15:0] term_i,
  output logic        tc_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != term_i)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/n64adv2_hdmi_clksw_ctrl.sv
// rtl/n64adv2_hdmi_clksw_ctrl.sv - HDMI output clock select / hold-reset sequencer
// Optional feature macro: HDMI_CLKSW_ACK_TIMEOUT_EN (reconfiguration acknowledge timeout).
// Ports:
//   SYS_CLK_i          in   system clock
//   nSRST_i            in   asynchronous active-low reset
//   HDMI_cfg_done_i    in   transmitter initial configuration done (synchronised)
//   HDMI_PLL_locked_i  in   HDMI PLL lock (synchronised)
//   clksel_req_i       in   requested select, 0 = main, 1 = sub
//   reconfig_ack_i     in   NIOS reconfiguration acknowledge (level)
//   clksel_o           out  applied clock-control select
//   HDMI_hold_nRST_o   out  active-low HDMI pipeline hold
//   HDMI_mute_o        out  transmitter AV mute request
//   reconfig_req_o     out  reconfiguration request (level)
//   busy_o             out  sequencer not idle
//   timeout_o          out  sticky acknowledge-timeout flag
module n64adv2_hdmi_clksw_ctrl
  import n64adv2_hdmi_clksw_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MUTE_CYCLES     = 256,
  parameter int SETTLE_CYCLES   = 64,
  parameter int ACK_TIMEOUT     = 65535
) (
  input  logic SYS_CLK_i,
  input  logic nSRST_i,
  input  logic HDMI_cfg_done_i,
  input  logic HDMI_PLL_locked_i,
  input  logic clksel_req_i,
  input  logic reconfig_ack_i,
  output logic clksel_o,
  output logic HDMI_hold_nRST_o,
  output logic HDMI_mute_o,
  output logic reconfig_req_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam logic [15:0] DEB_TC    = cycles_to_tc(DEBOUNCE_CYCLES);
  localparam logic [15:0] MUTE_TC   = cycles_to_tc(MUTE_CYCLES);
  localparam logic [15:0] SETTLE_TC = cycles_to_tc(SETTLE_CYCLES);

  clksw_state_e state_q, state_d;
  logic clksel_q, clksel_d;
  logic target_q, target_d;
  logic hold_q, hold_d;
  logic mute_q, mute_d;
  logic rreq_q, rreq_d;
  logic busy_q, busy_d;
  logic timeout_q, timeout_d;

  logic        mismatch;
  logic        cnt_load;
  logic [15:0] cnt_term;
  logic        cnt_tc;
  logic        tmo_tc;

  assign mismatch = (clksel_req_i != clksel_q);

  // One counter serves debounce, mute and settle: it restarts from 0 on every
  // state change, and in IDLE any matching sample restarts the debounce.
  always_comb begin
    cnt_term = 16'd0;
    case (state_q)
      ST_IDLE:   cnt_term = DEB_TC;
      ST_MUTE:   cnt_term = MUTE_TC;
      ST_SETTLE: cnt_term = SETTLE_TC;
      default:   cnt_term = 16'd0;
    endcase
    cnt_load = (state_d != state_q) || ((state_q == ST_IDLE) && !mismatch);
  end

  n64adv2_cycle_counter u_seq_cnt (
    .clk_i      (SYS_CLK_i),
    .rst_n_i    (nSRST_i),
    .load_i     (cnt_load),
    .en_i       (1'b1),
    .load_val_i (16'd0),
    .term_i     (cnt_term),
    .tc_o       (cnt_tc)
  );

`ifdef HDMI_CLKSW_ACK_TIMEOUT_EN
  // Held at 0 outside RELEASE, so the N-th RELEASE cycle sees N-1.
  n64adv2_cycle_counter u_tmo_cnt (
    .clk_i      (SYS_CLK_i),
    .rst_n_i    (nSRST_i),
    .load_i     (state_q != ST_RELEASE),
    .en_i       (1'b1),
    .load_val_i (16'd0),
    .term_i     (cycles_to_tc(ACK_TIMEOUT)),
    .tc_o       (tmo_tc)
  );
`else
  // No timeout hardware: this is constant false for any legal ACK_TIMEOUT.
  assign tmo_tc = (ACK_TIMEOUT < 0);
`endif

  always_comb begin
    state_d   = state_q;
    clksel_d  = clksel_q;
    target_d  = target_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_BOOT: begin
        if (HDMI_cfg_done_i) begin
          clksel_d = clksel_req_i;
          state_d  = ST_SETTLE;
        end
      end
      ST_IDLE: begin
        if (mismatch && cnt_tc) begin
          target_d = clksel_req_i;
          state_d  = ST_MUTE;
        end
      end
      ST_MUTE: begin
        if (cnt_tc) begin
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        clksel_d = target_q;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_tc && HDMI_PLL_locked_i) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (reconfig_ack_i) begin
          state_d = ST_IDLE;
        end else if (tmo_tc) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Losing the transmitter configuration overrides everything.
    if (!HDMI_cfg_done_i) begin
      state_d = ST_BOOT;
    end

    // Outputs are registered from the next state so they line up with it.
    hold_d = (state_d == ST_IDLE) || (state_d == ST_MUTE) || (state_d == ST_RELEASE);
    mute_d = (state_d != ST_IDLE);
    rreq_d = (state_d == ST_RELEASE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge SYS_CLK_i or negedge nSRST_i) begin
    if (!nSRST_i) begin
      state_q   <= ST_BOOT;
      clksel_q  <= CLKSEL_MAIN;
      target_q  <= CLKSEL_MAIN;
      hold_q    <= 1'b0;
      mute_q    <= 1'b1;
      rreq_q    <= 1'b0;
      busy_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clksel_q  <= clksel_d;
      target_q  <= target_d;
      hold_q    <= hold_d;
      mute_q    <= mute_d;
      rreq_q    <= rreq_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign clksel_o         = clksel_q;
  assign HDMI_hold_nRST_o = hold_q;
  assign HDMI_mute_o      = mute_q;
  assign reconfig_req_o   = rreq_q;
  assign busy_o           = busy_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_n64adv2_hdmi_clksw_ctrl.sv
// tb/tb_n64adv2_hdmi_clksw_ctrl.sv - directed self-checking bench for n64adv2_hdmi_clksw_ctrl
module tb_n64adv2_hdmi_clksw_ctrl;
  import n64adv2_hdmi_clksw_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_done;
  logic pll_locked;
  logic req;
  logic ack;
  logic clksel;
  logic hold_n;
  logic mute;
  logic rreq;
  logic busy;
  logic tmo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  n64adv2_hdmi_clksw_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .MUTE_CYCLES     (256),
    .SETTLE_CYCLES   (64),
    .ACK_TIMEOUT     (100)
  ) dut (
    .SYS_CLK_i         (clk),
    .nSRST_i           (rst_n),
    .HDMI_cfg_done_i   (cfg_done),
    .HDMI_PLL_locked_i (pll_locked),
    .clksel_req_i      (req),
    .reconfig_ack_i    (ack),
    .clksel_o          (clksel),
    .HDMI_hold_nRST_o  (hold_n),
    .HDMI_mute_o       (mute),
    .reconfig_req_o    (rreq),
    .busy_o            (busy),
    .timeout_o         (tmo)
  );

  task automatic check(input string tag, input logic act, input logic exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_done = 1'b1; pll_locked = 1'b1; req = CLKSEL_SUB; ack = 1'b0;
    tick(3);
    check("rst_clksel", clksel, 1'b0);
    check("rst_hold",   hold_n, 1'b0);
    check("rst_mute",   mute,   1'b1);
    check("rst_rreq",   rreq,   1'b0);
    check("rst_busy",   busy,   1'b1);
    check("rst_tmo",    tmo,    1'b0);

    // Boot: select loaded on BOOT exit, then 64 SETTLE cycles before release.
    rst_n = 1'b1;
    tick(1);
    check("boot_clksel", clksel, CLKSEL_SUB);
    check("boot_hold",   hold_n, 1'b0);
    tick(63);
    check("boot_settle_hold", hold_n, 1'b0);
    tick(1);
    check("boot_rel_hold", hold_n, 1'b1);
    check("boot_rel_rreq", rreq,   1'b1);
    check("boot_rel_mute", mute,   1'b1);
    tick(5);
    check("boot_wait_rreq", rreq, 1'b1);
    check("boot_wait_busy", busy, 1'b1);
    ack = 1'b1;
    tick(1);
    check("idle_rreq", rreq,   1'b0);
    check("idle_busy", busy,   1'b0);
    check("idle_mute", mute,   1'b0);
    check("idle_hold", hold_n, 1'b1);
    ack = 1'b0;

    // Short request pulse is debounced away.
    req = CLKSEL_MAIN;
    tick(10);
    req = CLKSEL_SUB;
    tick(20);
    check("pulse_busy",   busy,   1'b0);
    check("pulse_clksel", clksel, CLKSEL_SUB);

    // Full switch to main: first mismatch sampled at edge k.
    req = CLKSEL_MAIN;
    tick(1);
    tick(14);
    check("deb_k14_busy", busy, 1'b0);
    tick(1);
    check("mute_entry_busy", busy,   1'b1);
    check("mute_entry_mute", mute,   1'b1);
    check("mute_entry_hold", hold_n, 1'b1);
    tick(256);
    check("switch_hold",   hold_n, 1'b0);
    check("switch_clksel", clksel, CLKSEL_SUB);
    tick(1);
    check("sw_k272_clksel", clksel, CLKSEL_MAIN);
    check("sw_k272_hold",   hold_n, 1'b0);
    check("sw_k272_mute",   mute,   1'b1);

    // PLL lock lost during SETTLE; ack already high when RELEASE is entered.
    pll_locked = 1'b0;
    tick(500);
    check("nolock_hold", hold_n, 1'b0);
    pll_locked = 1'b1;
    ack = 1'b1;
    tick(1);
    check("lock_rel_hold", hold_n, 1'b1);
    check("lock_rel_rreq", rreq,   1'b1);
    tick(1);
    check("ackhi_rreq", rreq, 1'b0);
    check("ackhi_busy", busy, 1'b0);
    check("ackhi_mute", mute, 1'b0);
    ack = 1'b0;

    // Switch to sub; a request change after MUTE entry is ignored.
    req = CLKSEL_SUB;
    tick(1);
    tick(15);
    check("mute2_busy", busy, 1'b1);
    req = CLKSEL_MAIN;
    tick(257);
    check("ignore_clksel", clksel, CLKSEL_SUB);
    check("ignore_hold",   hold_n, 1'b0);
    tick(64);
    check("rel2_hold", hold_n, 1'b1);
    check("rel2_rreq", rreq,   1'b1);
    ack = 1'b1;
    tick(1);
    check("idle2_busy", busy, 1'b0);
    ack = 1'b0;

    // IDLE re-compares: the remaining mismatch starts a new sequence.
    tick(16);
    check("recmp_busy", busy, 1'b1);
    check("recmp_mute", mute, 1'b1);
    tick(4);
    cfg_done = 1'b0;
    tick(1);
    check("cfgdrop_hold",   hold_n, 1'b0);
    check("cfgdrop_mute",   mute,   1'b1);
    check("cfgdrop_busy",   busy,   1'b1);
    check("cfgdrop_clksel", clksel, CLKSEL_SUB);
    check("cfgdrop_rreq",   rreq,   1'b0);
    cfg_done = 1'b1;
    tick(1);
    check("reboot_clksel", clksel, CLKSEL_MAIN);
    check("reboot_hold",   hold_n, 1'b0);
    tick(64);
    check("rel3_rreq", rreq, 1'b1);

`ifdef HDMI_CLKSW_ACK_TIMEOUT_EN
    tick(99);
    check("tmo_pre_rreq", rreq, 1'b1);
    check("tmo_pre_flag", tmo,  1'b0);
    tick(1);
    check("tmo_flag", tmo,  1'b1);
    check("tmo_rreq", rreq, 1'b0);
    check("tmo_busy", busy, 1'b0);
`else
    tick(150);
    check("notmo_rreq", rreq, 1'b1);
    check("notmo_busy", busy, 1'b1);
    check("notmo_flag", tmo,  1'b0);
    ack = 1'b1;
    tick(1);
    check("notmo_idle", busy, 1'b0);
    ack = 1'b0;
`endif

    // Asynchronous reset in the middle of a switch to sub.
    req = CLKSEL_SUB;
    tick(273);
    check("pre_arst_clksel", clksel, CLKSEL_SUB);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clksel", clksel, CLKSEL_MAIN);
    check("arst_hold",   hold_n, 1'b0);
    check("arst_mute",   mute,   1'b1);
    check("arst_busy",   busy,   1'b1);
    check("arst_rreq",   rreq,   1'b0);
    check("arst_tmo",    tmo,    1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
